// File: rtl/seg7_pkg.sv
// Shared types and the active-high hex font for the 7-segment scan driver.
// Pure declarations; no state, no latency.
// No handshake lives here.
package seg7_pkg;

    typedef enum logic {
        BLANK = 1'b0,
        ON    = 1'b1
    } scan_state_t;

    // Segment order {g,f,e,d,c,b,a}, 1 = lit.
    function automatic logic [6:0] hex_to_seg(input logic [3:0] nib);
        logic [6:0] seg;
        case (nib)
            4'h0:    seg = 7'h3F;
            4'h1:    seg = 7'h06;
            4'h2:    seg = 7'h5B;
            4'h3:    seg = 7'h4F;
            4'h4:    seg = 7'h66;
            4'h5:    seg = 7'h6D;
            4'h6:    seg = 7'h7D;
            4'h7:    seg = 7'h07;
            4'h8:    seg = 7'h7F;
            4'h9:    seg = 7'h6F;
            4'hA:    seg = 7'h77;
            4'hB:    seg = 7'h7C;
            4'hC:    seg = 7'h39;
            4'hD:    seg = 7'h5E;
            4'hE:    seg = 7'h79;
            default: seg = 7'h71;
        endcase
        return seg;
    endfunction

endpackage

// File: rtl/seg7_hex_decode.sv
// Nibble to active-high segment pattern.
// Combinational, zero latency.
// No backpressure.
module seg7_hex_decode
    import seg7_pkg::*;
(
    input  logic [3:0] nibble,
    output logic [6:0] seg
);

    assign seg = hex_to_seg(nibble);

endmodule

// File: rtl/seg7_scan_driver.sv
// Multiplexed common-anode 7-seg driver; values commit at frame start. SEG7_LZB_EN enables leading-zero blanking.
// Outputs registered; a new value appears from the next frame start after acceptance.
// value_ready low while a value waits in the pending buffer for the next frame boundary.
module seg7_scan_driver
    import seg7_pkg::*;
#(
    parameter int NUM_DIGITS     = 4,
    parameter int SCAN_CYCLES    = 50000,
    parameter int BLANK_CYCLES   = 500,
    parameter int ACTIVE_LOW_SEG = 1,
    parameter int ACTIVE_LOW_AN  = 1
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [4*NUM_DIGITS-1:0]   value_i,
    input  logic [NUM_DIGITS-1:0]     dp_i,
    input  logic                      value_valid,
    output logic                      value_ready,
    output logic [6:0]                seg_o,
    output logic                      dp_o,
    output logic [NUM_DIGITS-1:0]     an_o,
    output logic                      frame_done
);

    localparam int MAXC = (SCAN_CYCLES > BLANK_CYCLES) ? SCAN_CYCLES : BLANK_CYCLES;
    localparam int TW   = $clog2(MAXC + 1);
    localparam int IW   = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

    localparam logic [TW-1:0]         SCAN_LAST  = TW'(SCAN_CYCLES - 1);
    localparam logic [TW-1:0]         BLANK_LAST = TW'(BLANK_CYCLES - 1);
    localparam logic [IW-1:0]         IDX_LAST   = IW'(NUM_DIGITS - 1);
    localparam logic [6:0]            SEG_OFF    = (ACTIVE_LOW_SEG != 0) ? 7'h7F : 7'h00;
    localparam logic                  DP_OFF     = (ACTIVE_LOW_SEG != 0);
    localparam logic [NUM_DIGITS-1:0] AN_OFF     = (ACTIVE_LOW_AN != 0) ? '1 : '0;

    scan_state_t             state;
    logic [IW-1:0]           idx;
    logic [TW-1:0]           timer;
    logic [4*NUM_DIGITS-1:0] shadow_val;
    logic [NUM_DIGITS-1:0]   shadow_dp;
    logic [4*NUM_DIGITS-1:0] pend_val;
    logic [NUM_DIGITS-1:0]   pend_dp;

    logic                    commit;
    logic [4*NUM_DIGITS-1:0] cur_val;
    logic [NUM_DIGITS-1:0]   cur_dp;
    logic [3:0]              cur_nib;
    logic [6:0]              seg_act;
    logic                    show;
    logic [NUM_DIGITS-1:0]   an_sel;

    // The digit entering ON at idx 0 must already see the freshly committed value.
    assign commit  = (state == BLANK) && (timer == BLANK_LAST) && (idx == '0) && !value_ready;
    assign cur_val = commit ? pend_val : shadow_val;
    assign cur_dp  = commit ? pend_dp  : shadow_dp;
    assign cur_nib = cur_val[4*int'(idx) +: 4];

    seg7_hex_decode u_decode (
        .nibble (cur_nib),
        .seg    (seg_act)
    );

`ifdef SEG7_LZB_EN
    logic [NUM_DIGITS-1:0] lead_zero;
    logic                  zeros;

    always_comb begin
        lead_zero = '0;
        zeros     = 1'b1;
        for (int k = NUM_DIGITS - 1; k > 0; k--) begin
            zeros        = zeros & (cur_val[4*k +: 4] == 4'h0);
            lead_zero[k] = zeros;
        end
    end

    assign show = !lead_zero[idx];
`else
    assign show = 1'b1;
`endif

    assign an_sel = show ? (NUM_DIGITS'(1) << idx) : '0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= BLANK;
            idx         <= '0;
            timer       <= '0;
            shadow_val  <= '0;
            shadow_dp   <= '0;
            pend_val    <= '0;
            pend_dp     <= '0;
            value_ready <= 1'b1;
            an_o        <= AN_OFF;
            seg_o       <= SEG_OFF;
            dp_o        <= DP_OFF;
            frame_done  <= 1'b0;
        end else begin
            frame_done <= 1'b0;

            // Accept and commit are exclusive: accept needs the buffer empty, commit needs it full.
            if (value_valid && value_ready) begin
                pend_val    <= value_i;
                pend_dp     <= dp_i;
                value_ready <= 1'b0;
            end

            case (state)
                BLANK: begin
                    if (timer == BLANK_LAST) begin
                        state <= ON;
                        timer <= '0;
                        if (commit) begin
                            shadow_val  <= pend_val;
                            shadow_dp   <= pend_dp;
                            value_ready <= 1'b1;
                        end
                        an_o  <= an_sel ^ AN_OFF;
                        seg_o <= show ? (seg_act ^ SEG_OFF) : SEG_OFF;
                        dp_o  <= (show & cur_dp[idx]) ^ DP_OFF;
                    end else begin
                        timer <= timer + 1'b1;
                    end
                end
                ON: begin
                    if (timer == SCAN_LAST) begin
                        state      <= BLANK;
                        timer      <= '0;
                        idx        <= (idx == IDX_LAST) ? '0 : idx + 1'b1;
                        frame_done <= (idx == IDX_LAST);
                        an_o       <= AN_OFF;
                        seg_o      <= SEG_OFF;
                        dp_o       <= DP_OFF;
                    end else begin
                        timer <= timer + 1'b1;
                    end
                end
                default: begin
                    state <= BLANK;
                    timer <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Randomized bench for seg7_scan_driver (4 digits, 4 ON / 2 BLANK cycles, active-low).
// Expected outputs come from frame arithmetic on the edge count since reset release.
module tb_seg7_scan_driver;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [15:0] value_i;
    logic [3:0]  dp_i;
    logic        value_valid;
    logic        value_ready;
    logic [6:0]  seg_o;
    logic        dp_o;
    logic [3:0]  an_o;
    logic        frame_done;

    always #5 clk = ~clk;

    seg7_scan_driver #(
        .NUM_DIGITS     (4),
        .SCAN_CYCLES    (4),
        .BLANK_CYCLES   (2),
        .ACTIVE_LOW_SEG (1),
        .ACTIVE_LOW_AN  (1)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .value_i     (value_i),
        .dp_i        (dp_i),
        .value_valid (value_valid),
        .value_ready (value_ready),
        .seg_o       (seg_o),
        .dp_o        (dp_o),
        .an_o        (an_o),
        .frame_done  (frame_done)
    );

    // Active-high glyphs {g,f,e,d,c,b,a} for 0..F.
    logic [6:0] font [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                              7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

    typedef struct {
        logic [15:0] v;
        logic [3:0]  d;
        int          gap;
    } offer_t;

    offer_t q[$];
    offer_t cur;
    bit     holding, staged;
    int     gap;

    // Reference state: edges since reset release, displayed and pending values.
    int          e;
    logic [15:0] sh_v, pd_v;
    logic [3:0]  sh_dp, pd_dp;
    bit          rdy_m;

    int n_chk  = 0;
    int n_pass = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s edge=%0d got=%0h exp=%0h", tag, e, got, exp);
    endtask

    task automatic check_outputs();
        logic [3:0] ea;
        logic [6:0] es;
        logic       ed;
        logic [3:0] nib;
        int         d;
        bit         on, shown;
        on    = (e >= 2) && ((e % 6) >= 2);
        d     = (e / 6) % 4;
        shown = on;
`ifdef SEG7_LZB_EN
        if (on && d > 0 && (sh_v >> (4 * d)) == 16'h0) shown = 0;
`endif
        nib = 4'(sh_v >> (4 * d));
        if (shown) begin
            ea = ~(4'b0001 << d);
            es = ~font[nib];
            ed = ~sh_dp[d];
        end else begin
            ea = 4'hF;
            es = 7'h7F;
            ed = 1'b1;
        end
        check("an_o", 32'(an_o), 32'(ea));
        check("seg_o", 32'(seg_o), 32'(es));
        check("dp_o", 32'(dp_o), 32'(ed));
        check("value_ready", 32'(value_ready), 32'(rdy_m));
        check("frame_done", 32'(frame_done), 32'(e > 0 && (e % 24) == 0));
        check("an_onehot0", 32'($onehot0(~an_o)), 32'd1);
    endtask

    task automatic drive(input bit acc);
        if (holding && acc) begin
            holding     = 0;
            value_valid = 1'b0;
        end
        if (!holding) begin
            value_i = 16'($urandom);
            dp_i    = 4'($urandom);
            if (!staged && q.size() > 0) begin
                cur    = q.pop_front();
                staged = 1;
                gap    = cur.gap;
            end
            if (staged) begin
                if (gap == 0) begin
                    value_valid = 1'b1;
                    value_i     = cur.v;
                    dp_i        = cur.d;
                    holding     = 1;
                    staged      = 0;
                end else begin
                    gap--;
                end
            end
        end
    endtask

    task automatic step();
        bit acc;
        @(posedge clk);
        acc = value_valid && rdy_m;
        e++;
        if (acc) begin
            pd_v  = value_i;
            pd_dp = dp_i;
            rdy_m = 0;
        end else if (!rdy_m && (e % 24) == 2) begin
            sh_v  = pd_v;
            sh_dp = pd_dp;
            rdy_m = 1;
        end
        #1;
        check_outputs();
        drive(acc);
    endtask

    task automatic model_reset();
        e     = 0;
        sh_v  = '0;
        sh_dp = '0;
        pd_v  = '0;
        pd_dp = '0;
        rdy_m = 1;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_an"}, 32'(an_o), 32'hF);
        check({tag, "_seg"}, 32'(seg_o), 32'h7F);
        check({tag, "_dp"}, 32'(dp_o), 32'd1);
        check({tag, "_ready"}, 32'(value_ready), 32'd1);
        check({tag, "_frame_done"}, 32'(frame_done), 32'd0);
    endtask

    initial begin
        rst_n       = 1'b1;
        value_valid = 1'b0;
        value_i     = '0;
        dp_i        = '0;
        holding     = 0;
        staged      = 0;
        gap         = 0;
        model_reset();

        #1 rst_n = 1'b0;
        #2 check_reset_outputs("reset");
        @(negedge clk);
        rst_n = 1'b1;

        q.push_back('{16'h1234, 4'b0001, 30});
        q.push_back('{16'hAAAA, 4'b0000, 40});
        q.push_back('{16'hBBBB, 4'b1010, 0});
        q.push_back('{16'h0040, 4'b0110, 50});
        q.push_back('{16'h0000, 4'b1111, 50});
        q.push_back('{16'h0009, 4'b0000, 30});
        for (int i = 0; i < 10; i++)
            q.push_back('{16'($urandom), 4'($urandom), int'($urandom_range(0, 60))});
        drive(1'b0);

        for (int i = 0; i < 1600; i++) step();

        // Asynchronous reset in the middle of an ON slot.
        for (int i = 0; i < 12 && (e % 6) != 3; i++) step();
        #2 rst_n = 1'b0;
        #1 check_reset_outputs("midreset");
        value_valid = 1'b0;
        holding     = 0;
        staged      = 0;
        q.delete();
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
        for (int i = 0; i < 3; i++)
            q.push_back('{16'($urandom), 4'($urandom), int'($urandom_range(5, 40))});
        drive(1'b0);
        for (int i = 0; i < 200; i++) step();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
